// File: rtl/cpu_mem_pkg.sv
// Shared types and default parameters for the unified instruction/data memory arbiter.
package cpu_mem_pkg;

    localparam int DEF_ADDR_W       = 10;
    localparam int DEF_MEM_LATENCY  = 1;
    localparam int DEF_STARVE_LIMIT = 4;

    // Sized to cover MEM_LATENCY up to 7 and STARVE_LIMIT up to 15.
    localparam int CNT_W    = 3;
    localparam int STARVE_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational priority picker: data wins unless fetch has been starved for STARVE_LIMIT grants.
module mem_arb_pick
    import cpu_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                iReq,
    input  logic                dReq,
    input  logic [STARVE_W-1:0] starveCnt,
    output owner_t              grant,
    output logic                any_req
);

    always_comb begin
        grant   = OWN_I;
        any_req = iReq | dReq;
        if (dReq && !(iReq && (starveCnt == STARVE_W'(STARVE_LIMIT)))) begin
            grant = OWN_D;
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port word memory between instruction fetch and data access, one access at a time.
// Handshake: a requester raises req with stable address/data and holds it until its one-cycle ready pulse.
module unified_mem_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int MEM_LATENCY  = DEF_MEM_LATENCY,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iReq,
    input  logic [31:0]       iAddress,
    output logic              iReady,
    output logic [31:0]       iData,
    input  logic              dReq,
    input  logic              dWrite,
    input  logic [31:0]       dAddress,
    input  logic [31:0]       dWriteData,
    output logic              dReady,
    output logic [31:0]       dReadData,
    output logic [ADDR_W-1:0] memAddress,
    output logic [31:0]       memWriteData,
    output logic              memReadEnable,
    output logic              memWriteEnable,
    input  logic [31:0]       memReadData,
    output state_t            dbg_state
);

    state_t              state, state_d;
    owner_t              owner, owner_d, grant;
    logic                any_req, grant_store;
    logic                is_write, is_write_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic [STARVE_W-1:0] starve_cnt, starve_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [31:0]         wdata_d, idata_d, dread_d;
    logic                re_d, we_d, iready_d, dready_d;
    logic                addr_unused;

    assign addr_unused = ^{iAddress[31:ADDR_W+2], iAddress[1:0],
                           dAddress[31:ADDR_W+2], dAddress[1:0]};
    assign dbg_state   = state;
    assign grant_store = (grant == OWN_D) && dWrite;

    mem_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
        .iReq      (iReq),
        .dReq      (dReq),
        .starveCnt (starve_cnt),
        .grant     (grant),
        .any_req   (any_req)
    );

    always_comb begin
        state_d    = state;
        owner_d    = owner;
        is_write_d = is_write;
        cnt_d      = cnt;
        starve_d   = starve_cnt;
        addr_d     = memAddress;
        wdata_d    = memWriteData;
        idata_d    = iData;
        dread_d    = dReadData;
        re_d       = 1'b0;
        we_d       = 1'b0;
        iready_d   = 1'b0;
        dready_d   = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    owner_d    = grant;
                    is_write_d = grant_store;
                    addr_d     = (grant == OWN_D) ? dAddress[ADDR_W+1:2] : iAddress[ADDR_W+1:2];
                    if (grant_store) begin
                        wdata_d = dWriteData;
                    end
                    re_d  = !grant_store;
                    we_d  = grant_store;
                    cnt_d = '0;
                    // Only data grants that actually made fetch wait count toward starvation.
                    if ((grant == OWN_D) && iReq) begin
                        starve_d = (starve_cnt == STARVE_W'(STARVE_LIMIT)) ? starve_cnt
                                                                           : starve_cnt + 1'b1;
                    end else begin
                        starve_d = '0;
                    end
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                cnt_d = cnt + 1'b1;
                // cnt counts cycles since the strobe; read data is valid MEM_LATENCY cycles later.
                if (cnt == CNT_W'(MEM_LATENCY)) begin
                    if (!is_write) begin
                        if (owner == OWN_D) begin
                            dread_d = memReadData;
                        end else begin
                            idata_d = memReadData;
                        end
                    end
                    iready_d = (owner == OWN_I);
                    dready_d = (owner == OWN_D);
                    state_d  = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            owner          <= OWN_I;
            is_write       <= 1'b0;
            cnt            <= '0;
            starve_cnt     <= '0;
            memAddress     <= '0;
            memWriteData   <= '0;
            memReadEnable  <= 1'b0;
            memWriteEnable <= 1'b0;
            iData          <= '0;
            dReadData      <= '0;
            iReady         <= 1'b0;
            dReady         <= 1'b0;
        end else begin
            state          <= state_d;
            owner          <= owner_d;
            is_write       <= is_write_d;
            cnt            <= cnt_d;
            starve_cnt     <= starve_d;
            memAddress     <= addr_d;
            memWriteData   <= wdata_d;
            memReadEnable  <= re_d;
            memWriteEnable <= we_d;
            iData          <= idata_d;
            dReadData      <= dread_d;
            iReady         <= iready_d;
            dReady         <= dready_d;
        end
    end

endmodule
